// File: rtl/mem_access_pkg.sv
// Shared types for the MEM stage: aluop encodings, pipeline payload structs,
// the transaction FSM state enum and small opcode classification helpers.
package project_types;

    typedef logic reset_status_t;
    localparam reset_status_t RST_ENABLE = 1'b1;

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
    localparam logic [7:0] EXE_LL_OP  = 8'b1111_0000;
    localparam logic [7:0] EXE_SC_OP  = 8'b1111_1000;

    typedef enum logic [1:0] {MEM_IDLE, MEM_WAIT, MEM_DONE} mem_state_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } reg_t;

    typedef struct packed {
        logic [7:0]  aluop;
        logic [31:0] reg2;
    } alu_t;

    typedef logic [31:0] ram_addr_t;

    typedef struct packed {
        logic        we;
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    function automatic logic is_store_op(input logic [7:0] op);
        return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP) || (op == EXE_SC_OP);
    endfunction

    function automatic logic is_mem_op(input logic [7:0] op);
        return is_store_op(op) || (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
               (op == EXE_LHU_OP) || (op == EXE_LW_OP) || (op == EXE_LL_OP);
    endfunction

endpackage

// File: rtl/mem_access_align.sv
// Byte-lane logic for big-endian data RAM: byte enables, store replication,
// load lane extraction with sign/zero extension, and misalignment detection.
module mem_align
    import project_types::*;
(
    input  logic [7:0]  aluop,
    input  logic [1:0]  offset,
    input  logic [31:0] store_src,
    input  logic [31:0] load_word,
    output logic [3:0]  sel,
    output logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic        misaligned
);
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [3:0]  byte_sel;
    logic [3:0]  half_sel;

    always_comb begin
        byte_lane = load_word[31:24];
        case (offset)
            2'b01:   byte_lane = load_word[23:16];
            2'b10:   byte_lane = load_word[15:8];
            2'b11:   byte_lane = load_word[7:0];
            default: byte_lane = load_word[31:24];
        endcase
        half_lane = offset[1] ? load_word[15:0] : load_word[31:16];
        byte_sel  = 4'b1000 >> offset;
        half_sel  = offset[1] ? 4'b0011 : 4'b1100;
    end

    always_comb begin
        sel        = 4'b0000;
        store_data = 32'h0;
        load_data  = 32'h0;
        misaligned = 1'b0;
        case (aluop)
            EXE_LB_OP: begin
                sel       = byte_sel;
                load_data = {{24{byte_lane[7]}}, byte_lane};
            end
            EXE_LBU_OP: begin
                sel       = byte_sel;
                load_data = {24'h0, byte_lane};
            end
            EXE_LH_OP: begin
                sel        = half_sel;
                misaligned = offset[0];
                load_data  = {{16{half_lane[15]}}, half_lane};
            end
            EXE_LHU_OP: begin
                sel        = half_sel;
                misaligned = offset[0];
                load_data  = {16'h0, half_lane};
            end
            EXE_LW_OP, EXE_LL_OP: begin
                sel        = 4'b1111;
                misaligned = |offset;
                load_data  = load_word;
            end
            EXE_SB_OP: begin
                sel        = byte_sel;
                store_data = {4{store_src[7:0]}};
            end
            EXE_SH_OP: begin
                sel        = half_sel;
                misaligned = offset[0];
                store_data = {2{store_src[15:0]}};
            end
            EXE_SW_OP, EXE_SC_OP: begin
                sel        = 4'b1111;
                misaligned = |offset;
                store_data = store_src;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM stage: passes ALU results through and runs request/ack data-RAM transactions.
// Define MEM_LLBIT_EN to add the LL/SC reservation bit.
module mem_access
    import project_types::*;
#(
    parameter int RAM_AW = 32
) (
    input  logic              clk,
    input  reset_status_t     rst,
    input  reg_t              mem_wreg_i,
    input  alu_t              mem_alu_i,
    input  logic [RAM_AW-1:0] mem_ramaddr_i,
    input  hilo_t             mem_hilo_i,
    output reg_t              wb_wreg_o,
    output hilo_t             wb_hilo_o,
    output logic              stallreq_o,
    output logic              addr_err_o,
    output logic              ram_req_o,
    output logic              ram_we_o,
    output logic [RAM_AW-1:0] ram_addr_o,
    output logic [3:0]        ram_sel_o,
    output logic [31:0]       ram_wdata_o,
    input  logic [31:0]       ram_rdata_i,
    input  logic              ram_ack_i
);
    mem_state_t  state_q, state_d;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  sel;
    logic [31:0] store_data;
    logic [31:0] load_data;
    logic        misaligned;
    logic        is_mem;
    logic        is_store;
    logic        is_sc;
    logic        sc_fail;
    logic        issue;

    mem_align u_align (
        .aluop      (mem_alu_i.aluop),
        .offset     (mem_ramaddr_i[1:0]),
        .store_src  (mem_alu_i.reg2),
        .load_word  (rdata_q),
        .sel        (sel),
        .store_data (store_data),
        .load_data  (load_data),
        .misaligned (misaligned)
    );

    assign is_mem   = is_mem_op(mem_alu_i.aluop);
    assign is_store = is_store_op(mem_alu_i.aluop);
    assign is_sc    = (mem_alu_i.aluop == EXE_SC_OP);

`ifdef MEM_LLBIT_EN
    logic llbit_q, llbit_d;

    // A failed SC resolves in IDLE without touching the bus.
    assign sc_fail = is_sc && !llbit_q;

    always_comb begin
        llbit_d = llbit_q;
        if (state_q == MEM_DONE && is_mem) begin
            if (mem_alu_i.aluop == EXE_LL_OP) begin
                llbit_d = 1'b1;
            end else if (is_sc) begin
                llbit_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            llbit_q <= 1'b0;
        end else begin
            llbit_q <= llbit_d;
        end
    end
`else
    assign sc_fail = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        rdata_d     = rdata_q;
        issue       = 1'b0;
        wb_wreg_o   = mem_wreg_i;
        wb_hilo_o   = mem_hilo_i;
        stallreq_o  = 1'b0;
        addr_err_o  = 1'b0;
        ram_req_o   = 1'b0;
        ram_we_o    = 1'b0;
        ram_addr_o  = '0;
        ram_sel_o   = 4'b0000;
        ram_wdata_o = 32'h0;

        if (rst == RST_ENABLE) begin
            wb_wreg_o = '0;
            wb_hilo_o = '0;
            state_d   = MEM_IDLE;
        end else if (is_mem) begin
            case (state_q)
                MEM_IDLE: begin
                    if (misaligned) begin
                        addr_err_o   = 1'b1;
                        wb_wreg_o.we = 1'b0;
                    end else if (sc_fail) begin
                        wb_wreg_o.we    = 1'b1;
                        wb_wreg_o.wdata = 32'h0;
                    end else begin
                        issue   = 1'b1;
                        state_d = ram_ack_i ? MEM_DONE : MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    issue = 1'b1;
                    if (ram_ack_i) begin
                        state_d = MEM_DONE;
                    end
                end
                MEM_DONE: begin
                    state_d = MEM_IDLE;
                    if (is_sc) begin
                        wb_wreg_o.we    = 1'b1;
                        wb_wreg_o.wdata = 32'd1;
                    end else if (!is_store) begin
                        wb_wreg_o.wdata = load_data;
                    end
                end
                default: state_d = MEM_IDLE;
            endcase

            // Register write is held off until DONE presents the final value.
            if (issue) begin
                if (ram_ack_i) begin
                    rdata_d = ram_rdata_i;
                end
                wb_wreg_o.we = 1'b0;
                stallreq_o   = 1'b1;
                ram_req_o    = 1'b1;
                ram_we_o     = is_store;
                ram_addr_o   = {mem_ramaddr_i[RAM_AW-1:2], 2'b00};
                ram_sel_o    = sel;
                ram_wdata_o  = is_store ? store_data : 32'h0;
            end
        end else begin
            state_d = MEM_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q <= MEM_IDLE;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed vector table, LL/SC and reset
// sequences, and randomized ops checked against a byte-lane reference model.
module tb_mem_access;
    import project_types::*;

    logic          clk;
    reset_status_t rst;
    reg_t          mem_wreg_i;
    alu_t          mem_alu_i;
    logic [31:0]   mem_ramaddr_i;
    hilo_t         mem_hilo_i;
    reg_t          wb_wreg_o;
    hilo_t         wb_hilo_o;
    logic          stallreq_o;
    logic          addr_err_o;
    logic          ram_req_o;
    logic          ram_we_o;
    logic [31:0]   ram_addr_o;
    logic [3:0]    ram_sel_o;
    logic [31:0]   ram_wdata_o;
    logic [31:0]   ram_rdata_i;
    logic          ram_ack_i;

    int checkCount = 0;
    int passCount  = 0;
`ifdef MEM_LLBIT_EN
    bit modelLl = 1'b0;
`endif

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] reg2;
        logic        weIn;
        logic [31:0] wdataIn;
        logic [31:0] rdata;
        int          delay;
        logic        expErr;
        logic        expReq;
        logic        expWe;
        logic [31:0] expWdata;
        logic [3:0]  expSel;
        logic        expRamWe;
        logic [31:0] expRamWdata;
    } vec_t;

    mem_access #(.RAM_AW(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_wreg_i    (mem_wreg_i),
        .mem_alu_i     (mem_alu_i),
        .mem_ramaddr_i (mem_ramaddr_i),
        .mem_hilo_i    (mem_hilo_i),
        .wb_wreg_o     (wb_wreg_o),
        .wb_hilo_o     (wb_hilo_o),
        .stallreq_o    (stallreq_o),
        .addr_err_o    (addr_err_o),
        .ram_req_o     (ram_req_o),
        .ram_we_o      (ram_we_o),
        .ram_addr_o    (ram_addr_o),
        .ram_sel_o     (ram_sel_o),
        .ram_wdata_o   (ram_wdata_o),
        .ram_rdata_i   (ram_rdata_i),
        .ram_ack_i     (ram_ack_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [95:0] actual, input logic [95:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: derives expectations from access size and big-endian offset arithmetic.
    function automatic vec_t modelOp(input vec_t vin);
        vec_t v = vin;
        int size = 0;
        bit isLoad = 1'b0;
        bit isSigned = 1'b0;
        int off = int'(v.addr & 32'h3);
        logic [31:0] lane;
        case (v.op)
            EXE_LB_OP:  begin size = 1; isLoad = 1'b1; isSigned = 1'b1; end
            EXE_LBU_OP: begin size = 1; isLoad = 1'b1; end
            EXE_LH_OP:  begin size = 2; isLoad = 1'b1; isSigned = 1'b1; end
            EXE_LHU_OP: begin size = 2; isLoad = 1'b1; end
            EXE_LW_OP, EXE_LL_OP: begin size = 4; isLoad = 1'b1; end
            EXE_SB_OP:  size = 1;
            EXE_SH_OP:  size = 2;
            EXE_SW_OP, EXE_SC_OP: size = 4;
            default:    size = 0;
        endcase
        v.expErr = (size == 2 && (off % 2) != 0) || (size == 4 && off != 0);
        v.expReq = (size != 0) && !v.expErr;
        v.expRamWe = (size != 0) && !isLoad;
        v.expSel = (size == 1) ? 4'(1 << (3 - off)) : (size == 2) ? 4'(3 << (2 - off)) :
                   (size == 4) ? 4'hF : 4'h0;
        v.expRamWdata = (size == 1) ? (v.reg2 & 32'hFF) * 32'h0101_0101 :
                        (size == 2) ? (v.reg2 & 32'hFFFF) * 32'h0001_0001 : v.reg2;
        v.expWe = v.expErr ? 1'b0 : v.weIn;
        v.expWdata = v.wdataIn;
        if (isLoad && size == 1) begin
            lane = (v.rdata >> ((3 - off) * 8)) & 32'hFF;
            v.expWdata = (isSigned && lane >= 32'h80) ? (lane | 32'hFFFF_FF00) : lane;
        end else if (isLoad && size == 2) begin
            lane = (v.rdata >> ((2 - off) * 8)) & 32'hFFFF;
            v.expWdata = (isSigned && lane >= 32'h8000) ? (lane | 32'hFFFF_0000) : lane;
        end else if (isLoad) begin
            v.expWdata = v.rdata;
        end
        if (v.op == EXE_SC_OP && !v.expErr) begin
            v.expWe = 1'b1;
            v.expWdata = 32'd1;
`ifdef MEM_LLBIT_EN
            if (modelLl) begin
                modelLl = 1'b0;
            end else begin
                v.expReq = 1'b0;
                v.expWdata = 32'd0;
            end
`endif
        end
`ifdef MEM_LLBIT_EN
        if (v.op == EXE_LL_OP && !v.expErr) begin
            modelLl = 1'b1;
        end
`endif
        return v;
    endfunction

    // Runs one op from posedge+1 through its last cycle in the stage, checking each cycle.
    task automatic applyStimulus(input vec_t v);
        hilo_t hiloVal;
        logic [4:0] waddrVal;
        hiloVal.we = 1'($urandom_range(1));
        hiloVal.hi = $urandom;
        hiloVal.lo = $urandom;
        waddrVal = 5'($urandom);
        mem_wreg_i.we    = v.weIn;
        mem_wreg_i.waddr = waddrVal;
        mem_wreg_i.wdata = v.wdataIn;
        mem_alu_i.aluop  = v.op;
        mem_alu_i.reg2   = v.reg2;
        mem_ramaddr_i    = v.addr;
        mem_hilo_i       = hiloVal;
        ram_ack_i   = v.expReq ? (v.delay == 0) : 1'($urandom_range(1));
        ram_rdata_i = (v.expReq && v.delay == 0) ? v.rdata : $urandom;
        #1;
        checkOutput("wb_hilo", wb_hilo_o, hiloVal);
        checkOutput("addr_err", addr_err_o, v.expErr);
        if (!v.expReq) begin
            checkOutput("ram_req_idle", ram_req_o, 1'b0);
            checkOutput("stall_idle", stallreq_o, 1'b0);
            checkOutput("wb_we", wb_wreg_o.we, v.expWe);
            if (v.expWe) begin
                checkOutput("wb_waddr", wb_wreg_o.waddr, waddrVal);
                checkOutput("wb_wdata", wb_wreg_o.wdata, v.expWdata);
            end
            @(posedge clk); #1;
        end else begin
            for (int c = 0; c <= v.delay; c++) begin
                if (c > 0) begin
                    ram_ack_i   = (c == v.delay);
                    ram_rdata_i = (c == v.delay) ? v.rdata : $urandom;
                    #1;
                end
                checkOutput("ram_req", ram_req_o, 1'b1);
                checkOutput("stall", stallreq_o, 1'b1);
                checkOutput("ram_addr", ram_addr_o, v.addr & 32'hFFFF_FFFC);
                checkOutput("ram_sel", ram_sel_o, v.expSel);
                checkOutput("ram_we", ram_we_o, v.expRamWe);
                if (v.expRamWe) begin
                    checkOutput("ram_wdata", ram_wdata_o, v.expRamWdata);
                end
                @(posedge clk); #1;
            end
            ram_ack_i   = 1'($urandom_range(1));
            ram_rdata_i = $urandom;
            #1;
            checkOutput("done_req", ram_req_o, 1'b0);
            checkOutput("done_stall", stallreq_o, 1'b0);
            checkOutput("done_wb_we", wb_wreg_o.we, v.expWe);
            if (v.expWe) begin
                checkOutput("done_wb_waddr", wb_wreg_o.waddr, waddrVal);
                checkOutput("done_wb_wdata", wb_wreg_o.wdata, v.expWdata);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_wb_wreg"}, wb_wreg_o, 38'h0);
        checkOutput({tag, "_wb_hilo"}, wb_hilo_o, 65'h0);
        checkOutput({tag, "_stall"}, stallreq_o, 1'b0);
        checkOutput({tag, "_err"}, addr_err_o, 1'b0);
        checkOutput({tag, "_req"}, ram_req_o, 1'b0);
        checkOutput({tag, "_we"}, ram_we_o, 1'b0);
        checkOutput({tag, "_addr"}, ram_addr_o, 32'h0);
        checkOutput({tag, "_sel"}, ram_sel_o, 4'h0);
        checkOutput({tag, "_wdata"}, ram_wdata_o, 32'h0);
    endtask

    vec_t vecTable[14];
    logic [7:0] opList[12];

    initial begin
        vec_t v;
        vecTable[0]  = '{8'h20, 32'h0, 32'h0, 1'b1, 32'h0000_1234, 32'h0, 0, 1'b0, 1'b0, 1'b1, 32'h0000_1234, 4'h0, 1'b0, 32'h0};
        vecTable[1]  = '{EXE_LB_OP, 32'h103, 32'h0, 1'b1, 32'hDEAD, 32'h1122_3380, 0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FF80, 4'b0001, 1'b0, 32'h0};
        vecTable[2]  = '{EXE_LBU_OP, 32'h103, 32'h0, 1'b1, 32'hDEAD, 32'h1122_3380, 0, 1'b0, 1'b1, 1'b1, 32'h0000_0080, 4'b0001, 1'b0, 32'h0};
        vecTable[3]  = '{EXE_SH_OP, 32'h202, 32'hABCD_5678, 1'b0, 32'h0, 32'h0, 3, 1'b0, 1'b1, 1'b0, 32'h0, 4'b0011, 1'b1, 32'h5678_5678};
        vecTable[4]  = '{EXE_LW_OP, 32'h102, 32'h0, 1'b1, 32'hDEAD, 32'h0, 0, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0};
        vecTable[5]  = '{EXE_LH_OP, 32'h102, 32'h0, 1'b1, 32'h0, 32'h1122_3380, 0, 1'b0, 1'b1, 1'b1, 32'h0000_3380, 4'b0011, 1'b0, 32'h0};
        vecTable[6]  = '{EXE_LH_OP, 32'h100, 32'h0, 1'b1, 32'h0, 32'h8899_AABB, 1, 1'b0, 1'b1, 1'b1, 32'hFFFF_8899, 4'b1100, 1'b0, 32'h0};
        vecTable[7]  = '{EXE_LHU_OP, 32'h100, 32'h0, 1'b1, 32'h0, 32'h8899_AABB, 0, 1'b0, 1'b1, 1'b1, 32'h0000_8899, 4'b1100, 1'b0, 32'h0};
        vecTable[8]  = '{EXE_SB_OP, 32'h101, 32'h1234_565A, 1'b0, 32'h0, 32'h0, 2, 1'b0, 1'b1, 1'b0, 32'h0, 4'b0100, 1'b1, 32'h5A5A_5A5A};
        vecTable[9]  = '{EXE_SW_OP, 32'h104, 32'hCAFE_F00D, 1'b0, 32'h0, 32'h0, 0, 1'b0, 1'b1, 1'b0, 32'h0, 4'b1111, 1'b1, 32'hCAFE_F00D};
        vecTable[10] = '{EXE_SW_OP, 32'h106, 32'hCAFE_F00D, 1'b0, 32'h0, 32'h0, 0, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0};
        vecTable[11] = '{EXE_SH_OP, 32'h201, 32'hABCD_5678, 1'b0, 32'h0, 32'h0, 0, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0};
        vecTable[12] = '{EXE_LW_OP, 32'h108, 32'h0, 1'b1, 32'h0, 32'h0102_0304, 1, 1'b0, 1'b1, 1'b1, 32'h0102_0304, 4'b1111, 1'b0, 32'h0};
        vecTable[13] = '{EXE_LB_OP, 32'h100, 32'h0, 1'b1, 32'h0, 32'h7F00_0000, 0, 1'b0, 1'b1, 1'b1, 32'h0000_007F, 4'b1000, 1'b0, 32'h0};
        opList = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP, EXE_SB_OP,
                   EXE_SH_OP, EXE_SW_OP, EXE_LL_OP, EXE_SC_OP, 8'h20, 8'h25};

        // Reset with a live load on the inputs: every output must stay at zero.
        rst = RST_ENABLE;
        mem_wreg_i = '{we: 1'b1, waddr: 5'd3, wdata: 32'h1111_2222};
        mem_alu_i = '{aluop: EXE_LW_OP, reg2: 32'h3333_4444};
        mem_ramaddr_i = 32'h100;
        mem_hilo_i = '{we: 1'b1, hi: 32'h5555_6666, lo: 32'h7777_8888};
        ram_ack_i = 1'b1;
        ram_rdata_i = 32'h9999_AAAA;
        @(posedge clk); #1;
        checkAllZero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecTable[i]);
        end

        v = '{default: 0};
        v.op = EXE_LL_OP; v.addr = 32'h300; v.weIn = 1'b1; v.rdata = 32'h55AA_0001; v.delay = 1;
        applyStimulus(modelOp(v));
        v.op = EXE_SC_OP; v.reg2 = 32'h0BAD_CAFE; v.delay = 0;
        applyStimulus(modelOp(v));
        v.delay = 2;
        applyStimulus(modelOp(v));

        // Reset while stalled in WAIT abandons the access.
        mem_alu_i = '{aluop: EXE_LW_OP, reg2: 32'h0};
        mem_ramaddr_i = 32'h400;
        ram_ack_i = 1'b0;
        #1;
        checkOutput("pre_reset_req", ram_req_o, 1'b1);
        @(posedge clk); #1;
        checkOutput("wait_req", ram_req_o, 1'b1);
        rst = RST_ENABLE;
        #1;
        checkAllZero("midreset");
        @(posedge clk); #1;
        rst = 1'b0;
`ifdef MEM_LLBIT_EN
        modelLl = 1'b0;
`endif
        v = '{default: 0};
        v.op = EXE_LW_OP; v.addr = 32'h400; v.weIn = 1'b1; v.rdata = 32'hFEED_BEEF;
        applyStimulus(modelOp(v));

        for (int i = 0; i < 80; i++) begin
            v = '{default: 0};
            v.op = opList[$urandom_range(11)];
            v.addr = 32'($urandom_range(4095));
            if (v.op == EXE_LL_OP || v.op == EXE_SC_OP) begin
                v.addr = v.addr & 32'hFFC;
            end
            v.reg2 = $urandom;
            v.weIn = 1'($urandom_range(1));
            v.wdataIn = $urandom;
            v.rdata = $urandom;
            v.delay = $urandom_range(3);
            applyStimulus(modelOp(v));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
